step_ctrl: RTL and testbench

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/dbg_pkg.sv | 26 ++
 rtl/step_ctrl_sync_edge.sv | 40 ++++
 rtl/step_ctrl.sv | 126 ++++++++++++
 tb/tb_step_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared debug package for step_ctrl: FSM state encoding, debug snapshot struct
// and the default hold/repeat timing constants.
package dbg_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  typedef struct packed {
    state_t state;
    logic   step_lvl;
    logic   mode_lvl;
  } dbg_t;

  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam int DEF_CNT_W         = 26;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_ctrl_sync_edge.sv
// Two-flop synchronizer plus an edge flop; rise only fires once the input has
// been seen low after reset, so a button held through reset is not a press.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_fill1;
  logic r_fill2;
  logic r_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_fill1 <= 1'b0;
      r_fill2 <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_s1    <= d;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_fill1 <= 1'b1;
      r_fill2 <= r_fill1;
      // r_s2 only reflects the real input once the pipeline has refilled.
      if (r_fill2 && !r_s2) r_armed <= 1'b1;
    end
  end

  assign q    = r_s2;
  assign rise = r_s2 & ~r_s3 & r_armed;

endmodule

// File: rtl/step_ctrl.sv
// CPU single-step / free-run clock-enable controller.
// Optional STEP_CTRL_AUTOREPEAT_EN adds hold-to-repeat stepping.
module step_ctrl
  import dbg_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_step,
  input  logic        btn_mode,
  input  logic        cpu_halt,
  output logic        step_en,
  output logic        run_mode,
  output logic [15:0] step_count,
  output dbg_t        dbg
);

  if (CNT_W < $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1)) begin : g_bad_cnt_w
    $error("step_ctrl: CNT_W too narrow for HOLD_CYCLES/REPEAT_CYCLES");
  end

  logic        w_step_lvl;
  logic        w_step_rise;
  logic        w_mode_lvl;
  logic        w_mode_rise;
  state_t      r_state;
  logic        r_step;
  logic        r_run;
  logic [15:0] r_step_count;

`ifdef STEP_CTRL_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  sync_edge u_sync_step (
    .clk   (clk),
    .reset (reset),
    .d     (btn_step),
    .q     (w_step_lvl),
    .rise  (w_step_rise)
  );

  sync_edge u_sync_mode (
    .clk   (clk),
    .reset (reset),
    .d     (btn_mode),
    .q     (w_mode_lvl),
    .rise  (w_mode_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_step       <= 1'b0;
      r_run        <= 1'b0;
      r_step_count <= 16'h0000;
`ifdef STEP_CTRL_AUTOREPEAT_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_step_count <= r_step_count + 16'(step_en);
      r_step       <= 1'b0;
      if (r_state == S_RUN) begin
        if (w_mode_rise || cpu_halt) begin
          r_state <= S_IDLE;
          r_run   <= 1'b0;
        end else begin
          r_step  <= 1'b1;
        end
      end else if (w_mode_rise) begin
        // Mode toggle beats a coincident step edge, which is dropped here.
        r_state <= S_RUN;
        r_run   <= 1'b1;
        r_step  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_step_rise) begin
              r_step  <= 1'b1;
`ifdef STEP_CTRL_AUTOREPEAT_EN
              r_cnt   <= '0;
              r_state <= S_HOLD;
`endif
            end
          end
`ifdef STEP_CTRL_AUTOREPEAT_EN
          S_HOLD: begin
            if (!w_step_lvl) begin
              r_state <= S_IDLE;
            end else if (r_cnt == HOLD_LAST) begin
              r_step  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_REPEAT;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
          S_REPEAT: begin
            if (!w_step_lvl) begin
              r_state <= S_IDLE;
            end else if (r_cnt == REP_LAST) begin
              r_step  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Halt gates the enable immediately, independent of the registered state.
  assign step_en    = r_step & ~cpu_halt;
  assign run_mode   = r_run;
  assign step_count = r_step_count;
  assign dbg        = '{state: r_state, step_lvl: w_step_lvl, mode_lvl: w_mode_lvl};

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl (HOLD_CYCLES=4, REPEAT_CYCLES=2); works with
// or without STEP_CTRL_AUTOREPEAT_EN defined.
module tb_step_ctrl;
  import dbg_pkg::*;

  localparam int HOLD = 4;
  localparam int REP  = 2;
`ifdef STEP_CTRL_AUTOREPEAT_EN
  localparam int HOLD20_PULSES = 9;
`else
  localparam int HOLD20_PULSES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_step = 1'b0;
  logic        btn_mode = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        step_en;
  logic        run_mode;
  logic [15:0] step_count;
  dbg_t        dbg;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // Scoreboard: cycles in which a step pulse / a mode toggle is expected.
  logic [31:0] exp_q[$];
  logic [31:0] mode_q[$];
  logic        run_active = 1'b0;
  logic [15:0] exp_cnt = 16'h0000;
  logic        pulse;
  logic        exp_step;

  step_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_step   (btn_step),
    .btn_mode   (btn_mode),
    .cpu_halt   (cpu_halt),
    .step_en    (step_en),
    .run_mode   (run_mode),
    .step_count (step_count),
    .dbg        (dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drivers change inputs at negedge; the monitor samples 1 time unit later.
  task automatic press_step(input int len);
    int k;
    int t;
    @(negedge clk);
    btn_step = 1'b1;
    k = cyc + 1;
    exp_q.push_back(32'(k + 2));
`ifdef STEP_CTRL_AUTOREPEAT_EN
    t = k + 2 + HOLD;
    while (t <= k + len + 1) begin
      exp_q.push_back(32'(t));
      t += REP;
    end
`else
    t = len;
`endif
    repeat (len) @(negedge clk);
    btn_step = 1'b0;
  endtask

  task automatic press_mode();
    @(negedge clk);
    btn_mode = 1'b1;
    mode_q.push_back(32'(cyc + 3));
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
  endtask

  task automatic halt_pulse();
    @(negedge clk);
    cpu_halt = 1'b1;
    repeat (2) @(negedge clk);
    cpu_halt = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    #1;
    while (mode_q.size() > 0 && mode_q[0] == 32'(cyc)) begin
      run_active = !run_active;
      void'(mode_q.pop_front());
    end
    pulse = (exp_q.size() > 0 && exp_q[0] == 32'(cyc));
    if (pulse) void'(exp_q.pop_front());
    exp_step = (pulse || run_active) && !cpu_halt;
    check("step_en", 32'(step_en), 32'(exp_step));
    check("run_mode", 32'(run_mode), 32'(run_active));
    check("step_count", 32'(step_count), 32'(exp_cnt));
    if (exp_step) exp_cnt = exp_cnt + 16'd1;
    if (run_active && cpu_halt) run_active = 1'b0;
    if (reset) begin
      exp_cnt = 16'h0000;
      run_active = 1'b0;
      exp_q.delete();
      mode_q.delete();
    end
  end

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    #2;
    check("reset_step_en", 32'(step_en), 32'd0);
    check("reset_run_mode", 32'(run_mode), 32'd0);
    check("reset_count", 32'(step_count), 32'd0);
    check("reset_state", 32'(dbg.state), 32'(S_IDLE));
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // short press: one pulse
    press_step(3);
    repeat (8) @(negedge clk);
    check("single_press_count", 32'(step_count), 32'd1);

    // long hold: auto-repeat when enabled
    press_step(20);
    repeat (8) @(negedge clk);
    check("hold20_count", 32'(step_count), 32'(1 + HOLD20_PULSES));

    // run mode, then halt
    press_mode();
    repeat (10) @(negedge clk);
    cpu_halt = 1'b1;
    #2;
    check("halt_same_cycle", 32'(step_en), 32'd0);
    check("halt_run_still", 32'(run_mode), 32'd1);
    @(negedge clk);
    #2;
    check("halt_run_cleared", 32'(run_mode), 32'd0);
    cpu_halt = 1'b0;
    repeat (4) @(negedge clk);

    // mode toggles back off with a second press
    press_mode();
    repeat (5) @(negedge clk);
    press_mode();
    repeat (5) @(negedge clk);
    check("mode_toggle_off", 32'(run_mode), 32'd0);

    // coincident step and mode edges: mode wins; step ignored while running
    @(negedge clk);
    btn_step = 1'b1;
    btn_mode = 1'b1;
    mode_q.push_back(32'(cyc + 3));
    repeat (3) @(negedge clk);
    btn_step = 1'b0;
    btn_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("coincide_run", 32'(run_mode), 32'd1);
    btn_step = 1'b1;
    repeat (4) @(negedge clk);
    btn_step = 1'b0;
    repeat (3) @(negedge clk);
    halt_pulse();
    repeat (4) @(negedge clk);

    // reset while held (mid-repeat when enabled); no step until re-press
    press_step(3);
    repeat (6) @(negedge clk);
    @(negedge clk);
    btn_step = 1'b1;
    exp_q.push_back(32'(cyc + 3));
`ifdef STEP_CTRL_AUTOREPEAT_EN
    for (int t = cyc + 3 + HOLD; t < cyc + 60; t += REP) exp_q.push_back(32'(t));
`endif
    repeat (12) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("held_after_reset_count", 32'(step_count), 32'd0);
    btn_step = 1'b0;
    repeat (5) @(negedge clk);
    press_step(3);
    repeat (6) @(negedge clk);
    check("repress_after_reset", 32'(step_count), 32'd1);

    // count wrap: free-run up to 16'hFFFF, halt, then one more step
    press_mode();
    hit = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (step_count == 16'hFFFF) begin
        cpu_halt = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    check("wrap_reached", 32'(hit), 32'd1);
    repeat (2) @(negedge clk);
    cpu_halt = 1'b0;
    repeat (3) @(negedge clk);
    check("wrap_preload", 32'(step_count), 32'hFFFF);
    press_step(3);
    repeat (6) @(negedge clk);
    check("wrap_zero", 32'(step_count), 32'd0);

    repeat (5) @(negedge clk);
    check("drain", 32'(exp_q.size() + mode_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
